// File: rtl/i2c_regbank_slave_if.sv
// I2C bus lines seen by the register-bank target.
// scl_in/sda_in: raw lines; sda_out/sda_oe: open-drain pull-down.
`timescale 1ns/1ps
interface i2c_regbank_slave_if;
  logic scl_in;
  logic sda_in;
  logic sda_out;
  logic sda_oe;

  modport master (
    output scl_in,
    output sda_in,
    input  sda_out,
    input  sda_oe
  );

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_out,
    output sda_oe
  );
endinterface

// File: rtl/i2c_regbank_slave.sv
// I2C target with a pointer-addressed register bank plus status byte.
// Ports: clk, rst_n, bus (I2C lines), reg_flat, wr_strobe, status_in, busy.
`timescale 1ns/1ps
module i2c_regbank_slave #(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int NUM_REGS = 8,
  parameter int FILT_LEN = 3,
  parameter logic [NUM_REGS*8-1:0] RESET_VALS = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_regbank_slave_if.slave    bus,
  output logic [NUM_REGS*8-1:0] reg_flat,
  output logic [NUM_REGS-1:0]   wr_strobe,
  input  logic [7:0]            status_in,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WACK, RDATA, RACK
  } state_t;

  localparam logic [7:0] NR8 = 8'(NUM_REGS);
  localparam logic [2:0] CMAX = 3'(FILT_LEN - 1);

  logic [1:0] scl_sy_q, sda_sy_q;
  logic       scl_f_q, sda_f_q;
  logic       scl_p_q, sda_p_q;
  logic [2:0] scl_cnt_q, sda_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sy_q  <= 2'b11;
      sda_sy_q  <= 2'b11;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      scl_sy_q <= {scl_sy_q[0], bus.scl_in};
      sda_sy_q <= {sda_sy_q[0], bus.sda_in};
      scl_p_q  <= scl_f_q;
      sda_p_q  <= sda_f_q;
      // a filtered line flips only after FILT_LEN differing samples
      if (scl_sy_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CMAX) begin
        scl_f_q   <= scl_sy_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 3'd1;
      end
      if (sda_sy_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CMAX) begin
        sda_f_q   <= sda_sy_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 3'd1;
      end
    end
  end

  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  state_t               state_q;
  logic [2:0]           bitcnt_q;
  logic [6:0]           sh_q;
  logic [7:0]           rsh_q;
  logic [7:0]           ptr_q;
  logic                 rw_q;
  logic                 ackph_q;
  logic                 oe_q;
  logic                 busy_q;
  logic [NUM_REGS-1:0]  strb_q;
  logic [NUM_REGS*8-1:0] regs_q;

  logic [7:0] byte_w;
  logic       last_bit;
  logic [7:0] ptr_nxt;
  logic [7:0] rd_val;

  assign byte_w   = {sh_q, sda_f_q};
  assign last_bit = (bitcnt_q == 3'd7);
  // the status slot wraps to 0; beyond it wraps mod 256
  assign ptr_nxt  = (ptr_q == NR8) ? 8'd0 : ptr_q + 8'd1;

  always_comb begin
    rd_val = 8'hFF;
    if (ptr_q == NR8) rd_val = status_in;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ptr_q == 8'(i)) rd_val = regs_q[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sh_q     <= '0;
      rsh_q    <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      ackph_q  <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      strb_q   <= '0;
      regs_q   <= RESET_VALS;
    end else begin
      strb_q <= '0;
      if (start) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        oe_q     <= 1'b0;
        ackph_q  <= 1'b0;
      end else if (stop) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
        ackph_q <= 1'b0;
      end else if (scl_rise) begin
        unique case (state_q)
          ADDR: begin
            sh_q     <= byte_w[6:0];
            bitcnt_q <= bitcnt_q + 3'd1;
            if (last_bit) begin
              if (byte_w[7:1] == I2C_ADDR) begin
                busy_q  <= 1'b1;
                rw_q    <= byte_w[0];
                ackph_q <= 1'b0;
                state_q <= ADDR_ACK;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          PTR: begin
            sh_q     <= byte_w[6:0];
            bitcnt_q <= bitcnt_q + 3'd1;
            if (last_bit) begin
              ptr_q   <= byte_w;
              ackph_q <= 1'b0;
              state_q <= PTR_ACK;
            end
          end
          WDATA: begin
            sh_q     <= byte_w[6:0];
            bitcnt_q <= bitcnt_q + 3'd1;
            if (last_bit) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (ptr_q == 8'(i)) begin
                  regs_q[i*8 +: 8] <= byte_w;
                  strb_q[i]        <= 1'b1;
                end
              end
              ptr_q   <= ptr_nxt;
              ackph_q <= 1'b0;
              state_q <= WACK;
            end
          end
          ADDR_ACK: begin
            if (ackph_q && rw_q) rsh_q <= rd_val;
          end
          RDATA: begin
            rsh_q    <= {rsh_q[6:0], 1'b0};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (last_bit) begin
              ptr_q   <= ptr_nxt;
              state_q <= RACK;
            end
          end
          RACK: begin
            if (!sda_f_q) begin
              rsh_q    <= rd_val;
              bitcnt_q <= '0;
              state_q  <= RDATA;
            end else begin
              state_q <= IDLE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        unique case (state_q)
          ADDR_ACK, PTR_ACK, WACK: begin
            if (!ackph_q) begin
              oe_q    <= 1'b1;
              ackph_q <= 1'b1;
            end else begin
              ackph_q  <= 1'b0;
              bitcnt_q <= '0;
              oe_q     <= 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                oe_q    <= ~rsh_q[7];
                state_q <= RDATA;
              end else if (state_q == ADDR_ACK) begin
                state_q <= PTR;
              end else begin
                state_q <= WDATA;
              end
            end
          end
          RDATA:   oe_q <= ~rsh_q[7];
          RACK:    oe_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_out = 1'b0;
  assign bus.sda_oe  = oe_q;
  assign busy        = busy_q;
  assign wr_strobe   = strb_q;
  assign reg_flat    = regs_q;

endmodule

// File: doc/i2c_regbank_slave.md
I2C_REGBANK_SLAVE -- requirements
Module: i2c_regbank_slave

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h50, 7-bit target address.
REQ-002 SHALL have parameter NUM_REGS, default 8, range 1..255, count of read/write registers at pointers 0..NUM_REGS-1.
REQ-003 SHALL have parameter FILT_LEN, default 3, range 1..8, glitch-filter sample count.
REQ-004 SHALL have parameter RESET_VALS, default all-zero, NUM_REGS*8 bits, reset value of register i in bits [8i+7:8i].
REQ-005 SHALL have port clk, input, 1 bit, system clock.
REQ-006 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-007 SHALL have ports scl_in and sda_in, input, 1 bit each, raw bus lines.
REQ-008 SHALL have ports sda_out and sda_oe, output, 1 bit each; sda_out is held 0 and sda_oe=1 pulls SDA low.
REQ-009 SHALL have port reg_flat, output, NUM_REGS*8 bits, register i at bits [8i+7:8i].
REQ-010 SHALL have port wr_strobe, output, NUM_REGS bits, per-register write pulse.
REQ-011 SHALL have port status_in, input, 8 bits, read-only value at pointer NUM_REGS.
REQ-012 SHALL have port busy, output, 1 bit, high while this target is addressed.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-flop synchronizers with reset value 1.
REQ-014 SHALL change a filtered line only after FILT_LEN consecutive identical synchronized samples that differ from its current value.
REQ-015 SHALL take all edge, START and STOP detection from the filtered lines only.
REQ-016 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-017 SHALL give START priority over STOP, and STOP priority over SCL edges, in the same cycle.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK.
REQ-019 SHALL, on START from any state (including a repeated START), enter ADDR, clear the bit counter, set sda_oe=0, and keep the pointer.
REQ-020 SHALL, on STOP, enter IDLE, set sda_oe=0 and set busy=0.
REQ-021 SHALL sample SDA on SCL rising edges, MSB first, 8 bits per byte.
REQ-022 SHALL, in ADDR, compare the 7-bit address; on mismatch enter IDLE with no ACK and leave busy unchanged.
REQ-023 SHALL, on an address match, set busy=1, enter ADDR_ACK, and then go to PTR if R/W=0 or RDATA if R/W=1.
REQ-024 SHALL, for a read, load the RDATA shift register with the value at the current pointer on the ADDR_ACK rising edge.
REQ-025 SHALL drive ACK (sda_oe=1) from the SCL falling edge after bit 8 to the next SCL falling edge, in ADDR_ACK, PTR_ACK and WACK.
REQ-026 SHALL ACK every byte after a matched address, including writes to invalid pointers.
REQ-027 SHALL load the pointer from the first written byte (PTR state); following bytes are data (WDATA/WACK loop).
REQ-028 SHALL, for each data byte at pointer p<NUM_REGS, update register p and pulse wr_strobe[p] for exactly one clk in the same cycle the update becomes visible on reg_flat.
REQ-029 SHALL ignore writes to pointers >= NUM_REGS, with no strobe.
REQ-030 SHALL return, for reads: register p if p<NUM_REGS, status_in if p==NUM_REGS (sampled at load), and 8'hFF otherwise.
REQ-031 SHALL, in RDATA, set sda_oe=~bit on each SCL falling edge; the target releases SDA in RACK.
REQ-032 SHALL, on the RACK rising edge, load the next byte and return to RDATA if master ACK (SDA=0); on NACK it enters IDLE and busy stays 1 until STOP.
REQ-033 SHALL auto-increment the pointer after each data byte written or read; from NUM_REGS it wraps to 0, and values above NUM_REGS increment modulo 256.
REQ-034 SHALL change sda_oe only on filtered SCL falling edges, or on START/STOP/reset release.

Reset
REQ-035 SHALL, on rst_n=0, immediately set: state IDLE, sda_oe=0, sda_out=0, busy=0, wr_strobe=0, pointer=0, reg_flat=RESET_VALS, filters=1.
REQ-036 SHALL treat reset mid-transaction as an abort; the transaction does not resume, and the next transfer requires a new START.

Verification
REQ-037 SHALL verify a write: START, 0xA0, 0x02, 0x11, 0x22, STOP -> reg2=0x11, reg3=0x22, wr_strobe pulses bits 2 then 3, and all 4 bytes are ACKed.
REQ-038 SHALL verify a combined read: START, 0xA0, 0x07, repeated START, 0xA1, read 3 bytes ACK/ACK/NACK with NUM_REGS=8 and status_in=0x5A -> bytes reg7, 0x5A, reg0.
REQ-039 SHALL verify a wrong address: START, 0xB0 -> no ACK, sda_oe never 1, busy stays 0, registers unchanged.
REQ-040 SHALL verify the glitch filter: a 2-clk SDA low pulse while SCL is high with FILT_LEN=3 -> no START detected and state remains IDLE.
REQ-041 SHALL verify reset mid-byte: assert rst_n during the 5th data bit of a write -> sda_oe=0 at once and reg_flat=RESET_VALS; a following full write succeeds.
REQ-042 SHALL verify an invalid pointer: write to pointer 0x20 -> ACKed, no strobe; reading pointer 0x20 -> 0xFF.
